// File: rtl/rshift_deserializer_if.sv
// Serial-in / parallel-out bus between a bit-stream producer, the
// deserializer and the word consumer.
interface rshift_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             sh_in;
    logic             sh_valid;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    bit_cnt;
    logic             busy;
    logic             overrun;

    modport master (
        output sh_in, sh_valid, clr, out_ready,
        input  out, out_valid, bit_cnt, busy, overrun
    );

    modport slave (
        input  sh_in, sh_valid, clr, out_ready,
        output out, out_valid, bit_cnt, busy, overrun
    );
endinterface

// File: rtl/rshift_deserializer.sv
// Serial-to-parallel receiver: shifts WIDTH bits into a working register and
// hands each completed word to a double-buffered valid/ready holding register.
module rshift_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rshift_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        if (MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], bus.sh_in};
        else           shifted = {bus.sh_in, shreg_q[WIDTH-1:1]};
    end

    assign complete = bus.sh_valid && (cnt_q == CW'(WIDTH - 1));

    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (bus.clr) begin
            state_d = IDLE;
            shreg_d = '0;
            out_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && bus.out_ready) valid_d = 1'b0;

            if (bus.sh_valid) begin
                shreg_d = shifted;
                if (complete) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // Holding register is free if empty or being drained on this edge.
                    if (!valid_q || bus.out_ready) begin
                        out_d   = shifted;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = SHIFT;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_rshift_deserializer.sv
// Scoreboard bench for rshift_deserializer: an MSB-first and an LSB-first
// instance driven from one scenario sequence.
module tb_rshift_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    rshift_deserializer_if #(.WIDTH(8)) ifm ();
    rshift_deserializer_if #(.WIDTH(8)) ifl ();

    rshift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
    rshift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends w MSB first; optional idle gap after gap_at bits; out_ready on the
    // last edge is rdy_last. exp_out/exp_ovr are the values after completion.
    task automatic send_msb(input logic [7:0] w, input int gap_at, input int gap_len,
                            input logic rdy_last, input logic [7:0] exp_out, input logic exp_ovr);
        for (int i = 7; i >= 0; i--) begin
            ifm.sh_in    = w[i];
            ifm.sh_valid = 1'b1;
            if (i == 0) begin
                ifm.out_ready = rdy_last;
                exp_q.push_back(exp_out);
            end
            tick();
            ifm.sh_valid  = 1'b0;
            ifm.out_ready = 1'b0;
            if (i != 0) begin
                total++;
                if (ifm.bit_cnt !== 3'(8 - i) || ifm.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL msb_progress: bit_cnt=%0d busy=%b, want bit_cnt=%0d busy=1", ifm.bit_cnt, ifm.busy, 8 - i);
                end
            end
            if ((8 - i) == gap_at) begin
                repeat (gap_len) begin
                    tick();
                    total++;
                    if (ifm.bit_cnt !== 3'(gap_at) || ifm.busy !== 1'b1) begin
                        bad++;
                        $display("FAIL msb_gap: bit_cnt=%0d busy=%b, want bit_cnt=%0d busy=1", ifm.bit_cnt, ifm.busy, gap_at);
                    end
                end
            end
        end
        total++;
        if (ifm.bit_cnt !== 3'd0 || ifm.busy !== 1'b0 || ifm.out_valid !== 1'b1 || ifm.overrun !== exp_ovr) begin
            bad++;
            $display("FAIL msb_complete: bit_cnt=%0d busy=%b valid=%b ovr=%b, want 0 0 1 %b",
                     ifm.bit_cnt, ifm.busy, ifm.out_valid, ifm.overrun, exp_ovr);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL msb_scoreboard: queue empty at completion, want one entry");
        end else begin
            exp_w = exp_q.pop_front();
            if (ifm.out !== exp_w) begin
                bad++;
                $display("FAIL msb_out: out=%h want %h", ifm.out, exp_w);
            end
        end
    endtask

    // Sends seq[0] first into the LSB-first instance.
    task automatic send_lsb(input logic [7:0] seq, input logic [7:0] exp_out);
        for (int i = 0; i < 8; i++) begin
            ifl.sh_in    = seq[i];
            ifl.sh_valid = 1'b1;
            if (i == 7) exp_q.push_back(exp_out);
            tick();
            ifl.sh_valid = 1'b0;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL lsb_scoreboard: queue empty at completion, want one entry");
        end else begin
            exp_w = exp_q.pop_front();
            if (ifl.out !== exp_w || ifl.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL lsb_out: out=%h valid=%b want %h valid=1", ifl.out, ifl.out_valid, exp_w);
            end
        end
    endtask

    task automatic pulse_ready_m(input logic [7:0] exp_out, input logic exp_ovr);
        ifm.out_ready = 1'b1;
        tick();
        ifm.out_ready = 1'b0;
        total++;
        if (ifm.out_valid !== 1'b0 || ifm.out !== exp_out || ifm.overrun !== exp_ovr) begin
            bad++;
            $display("FAIL ready_pulse: valid=%b out=%h ovr=%b, want 0 %h %b", ifm.out_valid, ifm.out, ifm.overrun, exp_out, exp_ovr);
        end
    endtask

    task automatic check_zero_m(input string name);
        total++;
        if (ifm.out !== 8'h00 || ifm.out_valid !== 1'b0 || ifm.overrun !== 1'b0 ||
            ifm.bit_cnt !== 3'd0 || ifm.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: out=%h valid=%b ovr=%b cnt=%0d busy=%b, want all zero",
                     name, ifm.out, ifm.out_valid, ifm.overrun, ifm.bit_cnt, ifm.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_zero_m("reset_msb");
        total++;
        if (ifl.out !== 8'h00 || ifl.out_valid !== 1'b0 || ifl.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_lsb: out=%h valid=%b ovr=%b, want 00 0 0", ifl.out, ifl.out_valid, ifl.overrun);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send_msb(8'h55, 0, 0, 1'b0, 8'h55, 1'b0);
        pulse_ready_m(8'h55, 1'b0);
    endtask

    task automatic test_gap();
        send_msb(8'hAA, 4, 3, 1'b0, 8'hAA, 1'b0);
        pulse_ready_m(8'hAA, 1'b0);
    endtask

    task automatic test_backpressure();
        send_msb(8'h55, 0, 0, 1'b0, 8'h55, 1'b0);
        send_msb(8'hAA, 0, 0, 1'b0, 8'h55, 1'b1);
        pulse_ready_m(8'h55, 1'b1);
    endtask

    task automatic test_accept_complete();
        ifm.clr = 1'b1;
        tick();
        ifm.clr = 1'b0;
        check_zero_m("clr_idle");
        send_msb(8'h55, 0, 0, 1'b0, 8'h55, 1'b0);
        send_msb(8'h0F, 0, 0, 1'b1, 8'h0F, 1'b0);
    endtask

    task automatic test_reset_clr();
        for (int i = 0; i < 5; i++) begin
            ifm.sh_in = 1'b1; ifm.sh_valid = 1'b1;
            tick();
        end
        ifm.sh_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_m("async_reset");
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ifm.sh_in = 1'b1; ifm.sh_valid = 1'b1;
            tick();
        end
        ifm.clr = 1'b1;
        ifm.sh_in = 1'b1;
        ifm.sh_valid = 1'b1;
        tick();
        ifm.clr = 1'b0;
        ifm.sh_valid = 1'b0;
        check_zero_m("sync_clr");
        send_msb(8'hC3, 0, 0, 1'b0, 8'hC3, 1'b0);
    endtask

    task automatic test_lsb_first();
        send_lsb(8'b0000_0001, 8'h01);
        ifl.out_ready = 1'b1;
        tick();
        ifl.out_ready = 1'b0;
        total++;
        if (ifl.out_valid !== 1'b0 || ifl.out !== 8'h01) begin
            bad++;
            $display("FAIL lsb_ready: valid=%b out=%h, want 0 01", ifl.out_valid, ifl.out);
        end
        send_lsb(8'b0101_0011, 8'h53);
    endtask

    initial begin
        ifm.sh_in = 1'b0; ifm.sh_valid = 1'b0; ifm.clr = 1'b0; ifm.out_ready = 1'b0;
        ifl.sh_in = 1'b0; ifl.sh_valid = 1'b0; ifl.clr = 1'b0; ifl.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_backpressure();
        test_accept_complete();
        test_reset_clr();
        test_lsb_first();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
